// File: rtl/ws2812_rx.sv
// ws2812_rx - WS2812B single-wire pixel decoder.
//
// Recovers 24-bit GRB pixels from a pulse-width-encoded serial line. Each
// bit is classified by the length of its high pulse. A long low gap (the
// WS2812B latch/reset time) ends a frame. Nothing is decoded until one full
// gap has been seen, so the decoder never locks onto the middle of a frame.
//
// Ports:
//   CLOCK_50     in   system clock (50 MHz)
//   rst_n        in   asynchronous active-low reset, released synchronously
//   din          in   serial line, asynchronous to CLOCK_50
//   red          out  last decoded red byte
//   green        out  last decoded green byte
//   blue         out  last decoded blue byte
//   pixel_valid  out  one-cycle strobe, red/green/blue just updated
//   pixel_index  out  index of the current pixel in its frame (saturates at 255)
//   frame_done   out  one-cycle strobe on a latch gap after at least one pixel
//   error        out  one-cycle strobe on a malformed bit or partial pixel
//   dout         out  (WS2812_RX_REPEAT_EN only) forwarded line: the first
//                     pixel of each frame is consumed, the rest is repeated
//
// Optional feature macro: WS2812_RX_REPEAT_EN
//
// Latency: pixel_valid rises on the 4th CLOCK_50 rising edge after the
// falling edge of the 24th bit on din (2 synchronizer stages, 1 registered
// edge strobe, 1 registered FSM output).

module ws2812_rx #(
    parameter int THRESH_HIGH  = 30,
    parameter int MIN_HIGH     = 5,
    parameter int MAX_HIGH     = 80,
    parameter int RESET_CYCLES = 2500,
    parameter int CNT_W        = 12
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic       din,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic       pixel_valid,
    output logic [7:0] pixel_index,
    output logic       frame_done,
    output logic       error
`ifdef WS2812_RX_REPEAT_EN
    ,
    output logic       dout
`endif
);

    // state    | meaning
    // ---------+--------------------------------------------------------
    // SYNC_GAP | waiting for a full low gap before trusting the line
    // ARMED    | frame boundary seen, waiting for the first rising edge
    // HIGH     | measuring the high part of a bit
    // LOW      | measuring the low part of a bit / watching for the gap
    typedef enum logic [1:0] {
        SYNC_GAP,
        ARMED,
        HIGH,
        LOW
    } state_t;

    localparam logic [CNT_W-1:0] T_THRESH = CNT_W'(THRESH_HIGH);
    localparam logic [CNT_W-1:0] T_MIN    = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0] T_MAX    = CNT_W'(MAX_HIGH);
    localparam logic [CNT_W-1:0] T_RESET  = CNT_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    // Reset: asserted asynchronously, released through two flops.
    logic [1:0] rst_q;
    logic       rst_i;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            rst_q <= '0;
        end else begin
            rst_q <= {rst_q[0], 1'b1};
        end
    end

    assign rst_i = rst_q[1];

    // Input conditioning: 2-FF synchronizer (ds), one delay for edge
    // detection, then registered edge strobes that drive the FSM.
    logic din_s1;
    logic ds;
    logic ds_r;
    logic rise_q;
    logic fall_q;

    always_ff @(posedge CLOCK_50 or negedge rst_i) begin
        if (!rst_i) begin
            din_s1 <= 1'b0;
            ds     <= 1'b0;
            ds_r   <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            din_s1 <= din;
            ds     <= din_s1;
            ds_r   <= ds;
            rise_q <= ds & ~ds_r;
            fall_q <= ~ds & ds_r;
        end
    end

    state_t           state;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] lcnt;
    logic [22:0]      shreg;
    logic [4:0]       bit_cnt;
    logic             have_pix;
    logic [23:0]      sh_next;

    // Shift register only needs 23 bits: the 24th bit goes straight into
    // the output bytes.
    assign sh_next = {shreg, (hcnt >= T_THRESH)};

    always_ff @(posedge CLOCK_50 or negedge rst_i) begin
        if (!rst_i) begin
            state       <= SYNC_GAP;
            hcnt        <= '0;
            lcnt        <= '0;
            shreg       <= '0;
            bit_cnt     <= '0;
            have_pix    <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            pixel_valid <= 1'b0;
            pixel_index <= '0;
            frame_done  <= 1'b0;
            error       <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            error       <= 1'b0;

            // Index advances the cycle after the pixel strobe.
            if (pixel_valid && (pixel_index != 8'hFF)) begin
                pixel_index <= pixel_index + 8'd1;
            end

            case (state)
                SYNC_GAP: begin
                    if (ds_r) begin
                        lcnt <= '0;
                    end else if (lcnt >= T_RESET) begin
                        state <= ARMED;
                    end else begin
                        lcnt <= lcnt + CNT_W'(1);
                    end
                end

                ARMED: begin
                    if (rise_q) begin
                        hcnt  <= CNT_W'(1);
                        state <= HIGH;
                    end
                end

                HIGH: begin
                    if ((hcnt > T_MAX) || (fall_q && (hcnt < T_MIN))) begin
                        error       <= 1'b1;
                        bit_cnt     <= '0;
                        pixel_index <= '0;
                        have_pix    <= 1'b0;
                        lcnt        <= '0;
                        state       <= SYNC_GAP;
                    end else if (fall_q) begin
                        shreg <= sh_next[22:0];
                        lcnt  <= CNT_W'(1);
                        state <= LOW;
                        if (bit_cnt == 5'd23) begin
                            green       <= sh_next[23:16];
                            red         <= sh_next[15:8];
                            blue        <= sh_next[7:0];
                            pixel_valid <= 1'b1;
                            bit_cnt     <= '0;
                            have_pix    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end else if (hcnt != CNT_SAT) begin
                        hcnt <= hcnt + CNT_W'(1);
                    end
                end

                LOW: begin
                    if (rise_q) begin
                        hcnt  <= CNT_W'(1);
                        state <= HIGH;
                    end else if (lcnt >= T_RESET) begin
                        if (bit_cnt != 5'd0) begin
                            error <= 1'b1;
                        end else if (have_pix) begin
                            frame_done <= 1'b1;
                        end
                        bit_cnt     <= '0;
                        pixel_index <= '0;
                        have_pix    <= 1'b0;
                        state       <= ARMED;
                    end else begin
                        lcnt <= lcnt + CNT_W'(1);
                    end
                end

                default: state <= SYNC_GAP;
            endcase
        end
    end

`ifdef WS2812_RX_REPEAT_EN
    // Forward the line only once this frame's first pixel has been taken.
    // The rising edge that opens the next frame arrives in ARMED, so it is
    // never forwarded.
    always_ff @(posedge CLOCK_50 or negedge rst_i) begin
        if (!rst_i) begin
            dout <= 1'b0;
        end else begin
            dout <= ((state == HIGH) || (state == LOW)) && have_pix && ds;
        end
    end
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx - self-checking bench for ws2812_rx.
// The model decodes each bit from the high width it drove (>= 30 -> 1),
// tracks gap/error sync state, and predicts pixels, frame_done and error
// counts, plus pixel_valid timing (4 rising edges after the 24th fall).

module tb_ws2812_rx;

    localparam int THRESH = 30;
    localparam int MINH   = 5;
    localparam int MAXH   = 80;
    localparam int RST_C  = 2500;
    localparam int GAP    = 2520;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din;
    logic [7:0] red, green, blue, pixel_index;
    logic       pixel_valid, frame_done, error;
`ifdef WS2812_RX_REPEAT_EN
    logic       dout;
`endif

    ws2812_rx dut (
        .CLOCK_50    (clk),
        .rst_n       (rst_n),
        .din         (din),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .pixel_valid (pixel_valid),
        .pixel_index (pixel_index),
        .frame_done  (frame_done),
        .error       (error)
`ifdef WS2812_RX_REPEAT_EN
        ,
        .dout        (dout)
`endif
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
        logic [7:0] idx;
    } pix_t;

    // Observed events.
    pix_t got_q[$];
    int   fd_seen  = 0;
    int   err_seen = 0;

    always @(negedge clk) begin
        if (pixel_valid === 1'b1) got_q.push_back('{cyc, green, red, blue, pixel_index});
        if (frame_done === 1'b1) fd_seen++;
        if (error === 1'b1) err_seen++;
    end

    // Checking counters.
    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    pix_t        exp_q[$];
    int          exp_fd   = 0;
    int          exp_err  = 0;
    int          got_rd   = 0;
    bit          armed    = 0;
    int          bits     = 0;
    int          pix      = 0;
    logic [23:0] acc      = '0;
    logic [7:0]  last_g   = '0;
    logic [7:0]  last_r   = '0;
    logic [7:0]  last_b   = '0;
    bit          rep_on   = 0;
    bit          phase1   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        armed = 0;
        bits  = 0;
        pix   = 0;
    endtask

    // One bit: h cycles high, l cycles low. Decoding comes from the width.
    task automatic drive_bit(input int h, input int l);
        int fall;
        din = 1'b1;
        repeat (h) @(negedge clk);
        din  = 1'b0;
        fall = cyc;
        if (armed) begin
            if (h < MINH || h > MAXH) begin
                exp_err++;
                model_reset();
            end else begin
                acc = {acc[22:0], (h >= THRESH) ? 1'b1 : 1'b0};
                bits++;
                if (bits % 24 == 0) begin
                    exp_q.push_back('{fall + 4, acc[23:16], acc[15:8], acc[7:0],
                                      (pix > 255) ? 8'd255 : 8'(pix)});
                    pix++;
                    last_g = acc[23:16];
                    last_r = acc[15:8];
                    last_b = acc[7:0];
                end
            end
        end
        repeat (l) @(negedge clk);
    endtask

    task automatic gap(input int n);
        din = 1'b0;
        repeat (n) @(negedge clk);
        if (n >= RST_C + 10) begin
            if (armed) begin
                if (bits % 24 != 0) exp_err++;
                else if (pix > 0) exp_fd++;
            end
            armed = 1;
            bits  = 0;
            pix   = 0;
        end
    endtask

    // mode 0: 40/20 and 20/40; mode 1: random widths; mode 2: width boundaries.
    task automatic send_pixel(input logic [23:0] px, input int mode);
        for (int i = 23; i >= 0; i--) begin
            int h, l;
            if (mode == 0) begin
                h = px[i] ? 40 : 20;
                l = px[i] ? 20 : 40;
            end else if (mode == 1) begin
                h = int'($urandom_range(80, 5));
                l = int'($urandom_range(30, 5));
            end else begin
                h = px[i] ? ((i % 2) ? 30 : 80) : ((i % 2) ? 29 : 5);
                l = 10;
            end
            drive_bit(h, l);
        end
    endtask

    task automatic check_results(input string tag);
        int ng = got_q.size() - got_rd;
        int n  = (ng < exp_q.size()) ? ng : exp_q.size();
        chk({tag, "_npix"}, ng, exp_q.size());
        for (int i = 0; i < n; i++) begin
            pix_t a = got_q[got_rd + i];
            pix_t e = exp_q[i];
            chk($sformatf("%s_p%0d_cyc", tag, i), a.c, e.c);
            chk($sformatf("%s_p%0d_g", tag, i), a.g, e.g);
            chk($sformatf("%s_p%0d_r", tag, i), a.r, e.r);
            chk($sformatf("%s_p%0d_b", tag, i), a.b, e.b);
            chk($sformatf("%s_p%0d_idx", tag, i), a.idx, e.idx);
        end
        got_rd = got_q.size();
        exp_q.delete();
        chk({tag, "_frame_done"}, fd_seen, exp_fd);
        chk({tag, "_error"}, err_seen, exp_err);
        chk({tag, "_red_hold"}, red, last_r);
        chk({tag, "_green_hold"}, green, last_g);
        chk({tag, "_blue_hold"}, blue, last_b);
    endtask

`ifdef WS2812_RX_REPEAT_EN
    logic [2:0] din_h = '0;
    always @(posedge clk) din_h <= {din_h[1:0], din};
    always @(negedge clk) begin
        if (rep_on) begin
            n_checks++;
            assert (dout === (phase1 ? din_h[2] : 1'b0))
            else begin
                n_fail++;
                $error("FAIL dout: observed %0b expected %0b", dout, phase1 ? din_h[2] : 1'b0);
            end
        end
    end
`endif

    initial begin
        rst_n = 1'b1;
        din   = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_red", red, 0);
        chk("rst_green", green, 0);
        chk("rst_blue", blue, 0);
        chk("rst_pixel_valid", pixel_valid, 0);
        chk("rst_pixel_index", pixel_index, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_error", error, 0);
        rst_n = 1'b1;
        model_reset();
        gap(GAP);

        // Single reference pixel.
        send_pixel(24'hA53CFF, 0);
        gap(GAP);
        check_results("single");

        // Three back-to-back pixels.
        send_pixel(24'h000000, 0);
        send_pixel(24'hFFFFFF, 0);
        send_pixel(24'h123456, 0);
        gap(GAP);
        check_results("three");

        // Width boundaries 5/29 -> 0, 30/80 -> 1.
        send_pixel(24'hA55AC3, 2);
        gap(GAP);
        check_results("bound");

        // Random widths over the whole legal range.
        for (int f = 0; f < 3; f++) begin
            int np = int'($urandom_range(2, 1));
            for (int p = 0; p < np; p++) send_pixel(24'h0, 1);
            gap(GAP);
            check_results($sformatf("rand%0d", f));
        end

        // Short glitch after 10 bits, further bits ignored until a gap.
        for (int i = 0; i < 10; i++) drive_bit(40, 20);
        drive_bit(3, 30);
        for (int i = 0; i < 30; i++) drive_bit((i % 3) ? 40 : 20, 30);
        gap(GAP);
        send_pixel(24'h0F1E2D, 0);
        gap(GAP);
        check_results("glitch");

        // Over-long high pulse.
        for (int i = 0; i < 5; i++) drive_bit(20, 40);
        drive_bit(90, 20);
        gap(GAP);
        send_pixel(24'h5A6B7C, 0);
        gap(GAP);
        check_results("long");

        // Partial pixel: 12 bits then gap.
        for (int i = 0; i < 12; i++) drive_bit((i % 2) ? 40 : 20, 30);
        gap(GAP);
        check_results("partial");

        // Reset in the middle of a pixel.
        for (int i = 0; i < 10; i++) drive_bit(40, 20);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_red", red, 0);
        chk("midrst_pixel_index", pixel_index, 0);
        chk("midrst_error", error, 0);
        last_r = '0;
        last_g = '0;
        last_b = '0;
        rst_n  = 1'b1;
        model_reset();

        // Toggling without a full gap: nothing decoded, no error.
        for (int i = 0; i < 30; i++)
            drive_bit(int'($urandom_range(80, 5)), int'($urandom_range(60, 10)));
        check_results("nogap");
        gap(GAP);
        send_pixel(24'($urandom), 0);
        gap(GAP);
        check_results("after_nogap");

        // Two pixels; in repeat builds dout forwards only the second.
        rep_on = 1;
        send_pixel(24'hC0FFEE, 0);
        phase1 = 1;
        send_pixel(24'h81A5E7, 0);
        gap(GAP);
        phase1 = 0;
        rep_on = 0;
        check_results("two");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ws2812_rx.md
Name: ws2812_rx

Overview:
- Single-wire WS2812B-format decoder that recovers 24-bit GRB pixels from a pulse-width-encoded serial line.
- Clocked from CLOCK_50. Classifies each bit by its high-pulse width, assembles pixels MSB-first, and detects the latch gap that ends a frame.
- Used as a loopback checker for the LED transmit path, and as an input stage when the board sits inside a WS2812B chain.

Parameters:
- THRESH_HIGH, 30: high-time in cycles; a bit whose high time is at or above this value decodes as 1, below it decodes as 0.
- MIN_HIGH, 5: high pulses shorter than this are glitches and raise an error.
- MAX_HIGH, 80: high pulses longer than this raise an error.
- RESET_CYCLES, 2500: line-low cycles that end a frame (50 us at 50 MHz).
- CNT_W, 12: width of the pulse and gap counters; must hold RESET_CYCLES.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- din  in  1  serial line, asynchronous to CLOCK_50
- red  out  8  last decoded red byte
- green  out  8  last decoded green byte
- blue  out  8  last decoded blue byte
- pixel_valid  out  1  one-cycle strobe; red/green/blue are new
- pixel_index  out  8  index of the current pixel within its frame, first pixel = 0, saturates at 255
- frame_done  out  1  one-cycle strobe on latch gap after at least one pixel
- error  out  1  one-cycle strobe on a malformed bit or a partial pixel

Behaviour:
- Reset:
  - All outputs are 0.
  - The FSM enters SYNC_GAP. Shift register, bit counter and pixel counter are 0.
  - The reset is applied asynchronously and released synchronously through a 2-FF release stage.
- Input conditioning: din passes through a 2-FF synchronizer giving ds, plus one more register for edge detection. All timing below is counted on ds.
- FSM states:
  - SYNC_GAP: count ds-low cycles; ds high clears the count. When the count reaches RESET_CYCLES, go to ARMED. Nothing is decoded before a full gap, so a mid-frame power-up never produces misaligned pixels.
  - ARMED: wait for a ds rising edge, then load hcnt=1 and go to HIGH.
  - HIGH: hcnt increments and saturates at 2^CNT_W-1.
    - If hcnt exceeds MAX_HIGH: pulse error, clear bit_cnt and pixel_index, go to SYNC_GAP.
    - On a ds falling edge with hcnt<MIN_HIGH: same error handling as above.
    - Otherwise: shift in bit (hcnt>=THRESH_HIGH), bit_cnt++, load lcnt=1, go to LOW.
  - LOW: lcnt increments.
    - On a ds rising edge: load hcnt=1 and go to HIGH. Low time is not checked for bit decoding.
    - When lcnt reaches RESET_CYCLES:
      - bit_cnt==0 and at least one pixel received: pulse frame_done.
      - bit_cnt!=0: pulse error and discard the partial pixel.
      - In both cases, clear pixel_index and the pixel count, then go to ARMED.
- Pixel assembly:
  - Bit order is G7..G0, R7..R0, B7..B0, first-received bit is MSB.
  - When the 24th bit shifts in, in the same cycle: bit_cnt returns to 0, green/red/blue register from the shift register, and pixel_valid pulses.
  - pixel_index shows the index of this pixel while pixel_valid is high, and increments the cycle after.
- Latency: pixel_valid asserts exactly 4 CLOCK_50 cycles after the falling edge of bit 24 on din.
- Simultaneous events: if the 24th-bit completion and a gap timeout could coincide, the completion wins; the gap timeout is evaluated only in LOW.
- red/green/blue hold their value until the next completed pixel. They are not cleared by error or frame_done.
- Reset mid-frame discards all partial state and returns to SYNC_GAP.

Optional Feature:
- Macro: WS2812_RX_REPEAT_EN
- Defined:
  - Adds output port dout (1 bit). dout = ds (registered) when the FSM is in HIGH or LOW and at least one pixel of the current frame has completed; otherwise dout = 0.
  - The first pixel is consumed and the remainder is forwarded, delayed 3 cycles, so the board can sit mid-chain.
  - The ds high pulse that starts the next frame's first bit is not forwarded, because the pixel count was cleared on the gap.
- Not defined: no dout port and no forwarding logic.

Test Plan:
- Line low for 2500 cycles, then one pixel G=0xA5 R=0x3C B=0xFF (1 = 40 high/20 low, 0 = 20 high/40 low), then a 2500-cycle gap -> one pixel_valid with green=0xA5, red=0x3C, blue=0xFF, pixel_index=0; then one frame_done; error never asserted.
- Three pixels 0x000000, 0xFFFFFF, 0x123456 back-to-back, then a gap -> pixel_valid three times with indices 0,1,2, exactly 4 cycles after each 24th falling edge; then frame_done once.
- din toggling with no 2500-cycle gap after reset -> no pixel_valid and no error until a full gap has been seen.
- After 10 valid bits, a 3-cycle high glitch -> error pulse; FSM in SYNC_GAP; a following clean frame decodes correctly with index 0.
- 12 bits, then a gap -> error pulse, no pixel_valid, no frame_done; output bytes keep their previous values.
- With WS2812_RX_REPEAT_EN defined, two pixels -> dout stays 0 for pixel 0 and reproduces the pixel-1 waveform delayed 3 cycles.
